// File: rtl/pipe_stage0_fetch.sv
// Pipeline stage 0 (instruction fetch) of the JAM-1 CPU.
//
// Owns the 16-bit program counter and drives the program-memory address.
// The fetched byte is latched into the register that feeds stage 1.
// NOP bubbles are inserted on bus loss, on fetch suppression from stage 1,
// and for a fixed flush window after a PC load.
//
// Ports:
//   clk           system clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   BusRequest    another master owns the bus; fetch stalls
//   FetchSuppress stage 1 asks for a held PC and a bubble
//   PCLoad        jump/branch taken; load PC from PCLoadValue
//   PCLoadValue   jump target
//   MemData       asynchronous program-memory read data for MemAddr
//   MemAddr       program-memory address (equals PC)
//   MemRead       fetch read strobe
//   PipeIn        registered instruction byte to stage 1
//   PipeValid     1 when PipeIn holds a real fetched byte
//   PC            current program counter
module pipe_stage0_fetch #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [7:0]  NOP_OPCODE   = 8'h00,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        BusRequest,
    input  logic        FetchSuppress,
    input  logic        PCLoad,
    input  logic [15:0] PCLoadValue,
    input  logic [7:0]  MemData,
    output logic [15:0] MemAddr,
    output logic        MemRead,
    output logic [7:0]  PipeIn,
    output logic        PipeValid,
    output logic [15:0] PC
);

    typedef enum logic [1:0] {
        StStart = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } state_e;

    localparam logic [2:0] FlushInit = 3'(FLUSH_CYCLES - 1);

    state_e      state_q;
    logic [2:0]  flush_cnt_q;
    logic [15:0] pc_q;
    logic [7:0]  pipe_in_q;
    logic        pipe_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            pipe_in_q    <= NOP_OPCODE;
            pipe_valid_q <= 1'b0;
            flush_cnt_q  <= 3'd0;
            state_q      <= StStart;
        end else if (PCLoad) begin
            // A load wins over stalls and restarts any flush in progress.
            pc_q         <= PCLoadValue;
            pipe_in_q    <= NOP_OPCODE;
            pipe_valid_q <= 1'b0;
            flush_cnt_q  <= FlushInit;
            state_q      <= (FLUSH_CYCLES == 1) ? StRun : StFlush;
        end else if (BusRequest) begin
            // Bus lost: everything frozen, flush window not consumed.
            pipe_in_q    <= NOP_OPCODE;
            pipe_valid_q <= 1'b0;
        end else if (FetchSuppress) begin
            pipe_in_q    <= NOP_OPCODE;
            pipe_valid_q <= 1'b0;
            unique case (state_q)
                StStart: state_q <= StRun;
                StFlush: begin
                    // Suppressed cycles still count towards the flush window.
                    if (flush_cnt_q == 3'd0) begin
                        state_q <= StRun;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end else begin
            unique case (state_q)
                StStart: begin
                    pipe_in_q    <= NOP_OPCODE;
                    pipe_valid_q <= 1'b0;
                    state_q      <= StRun;
                end
                StFlush: begin
                    // Discard the byte but keep prefetching.
                    pipe_in_q    <= NOP_OPCODE;
                    pipe_valid_q <= 1'b0;
                    pc_q         <= pc_q + 16'd1;
                    if (flush_cnt_q == 3'd0) begin
                        state_q <= StRun;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 3'd1;
                    end
                end
                default: begin
                    pipe_in_q    <= MemData;
                    pipe_valid_q <= 1'b1;
                    pc_q         <= pc_q + 16'd1;
                end
            endcase
        end
    end

    assign MemAddr   = pc_q;
    assign MemRead   = (state_q != StStart) && !BusRequest;
    assign PipeIn    = pipe_in_q;
    assign PipeValid = pipe_valid_q;
    assign PC        = pc_q;

endmodule

// File: tb/tb_pipe_stage0_fetch.sv
// Directed bench for pipe_stage0_fetch: memory returns addr[7:0] ^ 8'h5A.
module tb_pipe_stage0_fetch;

    logic        clk;
    logic        rst;
    logic        BusRequest;
    logic        FetchSuppress;
    logic        PCLoad;
    logic [15:0] PCLoadValue;
    logic [7:0]  MemData;
    logic [15:0] MemAddr;
    logic        MemRead;
    logic [7:0]  PipeIn;
    logic        PipeValid;
    logic [15:0] PC;

    int errors = 0;
    int checks = 0;

    pipe_stage0_fetch #(
        .RESET_VECTOR(16'h0000),
        .NOP_OPCODE  (8'h00),
        .FLUSH_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .BusRequest   (BusRequest),
        .FetchSuppress(FetchSuppress),
        .PCLoad       (PCLoad),
        .PCLoadValue  (PCLoadValue),
        .MemData      (MemData),
        .MemAddr      (MemAddr),
        .MemRead      (MemRead),
        .PipeIn       (PipeIn),
        .PipeValid    (PipeValid),
        .PC           (PC)
    );

    // Asynchronous program memory model.
    assign MemData = MemAddr[7:0] ^ 8'h5A;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] pipe, input logic valid,
                              input logic [15:0] pc);
        check_eq({tag, ".pipe"}, 32'(PipeIn), 32'(pipe));
        check_eq({tag, ".valid"}, 32'(PipeValid), 32'(valid));
        check_eq({tag, ".pc"}, 32'(PC), 32'(pc));
    endtask

    // Jump to target-2 and let the 2-cycle flush prefetch bring PC to target in StRun.
    task automatic go_to(input logic [15:0] target);
        PCLoad      = 1'b1;
        PCLoadValue = target - 16'd2;
        tick();
        PCLoad = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        BusRequest    = 1'b0;
        FetchSuppress = 1'b0;
        PCLoad        = 1'b0;
        PCLoadValue   = 16'h0000;

        // 1: reset release and normal fetch
        tick();
        expect_out("rst", 8'h00, 1'b0, 16'h0000);
        check_eq("rst.memread", 32'(MemRead), 32'd0);
        rst = 1'b0;
        tick();
        expect_out("start", 8'h00, 1'b0, 16'h0000);
        check_eq("start.memread", 32'(MemRead), 32'd1);
        tick();
        expect_out("f0", 8'h5A, 1'b1, 16'h0001);
        tick();
        expect_out("f1", 8'h5B, 1'b1, 16'h0002);
        tick();
        expect_out("f2", 8'h58, 1'b1, 16'h0003);
        tick();
        expect_out("f3", 8'h59, 1'b1, 16'h0004);

        // 2: jump from 0x0010 to 0x1234
        go_to(16'h0010);
        check_eq("j.pc_pre", 32'(PC), 32'h0010);
        PCLoad      = 1'b1;
        PCLoadValue = 16'h1234;
        tick();
        PCLoad = 1'b0;
        expect_out("j.load", 8'h00, 1'b0, 16'h1234);
        tick();
        expect_out("j.fl1", 8'h00, 1'b0, 16'h1235);
        check_eq("j.memread", 32'(MemRead), 32'd1);
        tick();
        expect_out("j.fl2", 8'h00, 1'b0, 16'h1236);
        tick();
        expect_out("j.fetch", 8'h6C, 1'b1, 16'h1237);

        // 3: bus loss at 0x0040
        go_to(16'h0040);
        BusRequest = 1'b1;
        #1;
        check_eq("bus.memread", 32'(MemRead), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("bus.stall", 8'h00, 1'b0, 16'h0040);
        end
        BusRequest = 1'b0;
        tick();
        expect_out("bus.rel", 8'h1A, 1'b1, 16'h0041);

        // 4: PC wrap
        go_to(16'hFFFF);
        tick();
        expect_out("wrap.ff", 8'hA5, 1'b1, 16'h0000);
        tick();
        expect_out("wrap.00", 8'h5A, 1'b1, 16'h0001);

        // 5: load beats bus request and suppress; bus stall freezes the flush
        PCLoad        = 1'b1;
        PCLoadValue   = 16'h0100;
        BusRequest    = 1'b1;
        FetchSuppress = 1'b1;
        tick();
        PCLoad        = 1'b0;
        FetchSuppress = 1'b0;
        expect_out("pri.load", 8'h00, 1'b0, 16'h0100);
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_out("pri.stall", 8'h00, 1'b0, 16'h0100);
        end
        BusRequest = 1'b0;
        tick();
        expect_out("pri.fl1", 8'h00, 1'b0, 16'h0101);
        tick();
        expect_out("pri.fl2", 8'h00, 1'b0, 16'h0102);
        tick();
        expect_out("pri.fetch", 8'h58, 1'b1, 16'h0103);

        // 6: reset in the second flush cycle
        PCLoad      = 1'b1;
        PCLoadValue = 16'h0200;
        tick();
        PCLoad = 1'b0;
        tick();
        expect_out("mid.fl1", 8'h00, 1'b0, 16'h0201);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("mid.rst", 8'h00, 1'b0, 16'h0000);
        check_eq("mid.memread", 32'(MemRead), 32'd0);
        tick();
        expect_out("mid.start", 8'h00, 1'b0, 16'h0000);
        tick();
        expect_out("mid.f0", 8'h5A, 1'b1, 16'h0001);

        // Fetch suppress in run holds PC
        FetchSuppress = 1'b1;
        tick();
        expect_out("sup.run", 8'h00, 1'b0, 16'h0001);
        FetchSuppress = 1'b0;
        tick();
        expect_out("sup.rel", 8'h5B, 1'b1, 16'h0002);

        // Fetch suppress during flush consumes a flush cycle
        PCLoad      = 1'b1;
        PCLoadValue = 16'h0300;
        tick();
        PCLoad        = 1'b0;
        FetchSuppress = 1'b1;
        tick();
        FetchSuppress = 1'b0;
        expect_out("supfl.sup", 8'h00, 1'b0, 16'h0300);
        tick();
        expect_out("supfl.fl", 8'h00, 1'b0, 16'h0301);
        tick();
        expect_out("supfl.fetch", 8'h5B, 1'b1, 16'h0302);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
